// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared types, opcode codes and trigger compare helper for the retire-trace buffer.
package cpu_trace_pkg;
    localparam int TR_PC_W   = 16;
    localparam int TR_INST_W = 32;
    localparam int TR_DATA_W = 16;
    localparam int TR_CCR_W  = 4;

    typedef struct packed {
        logic [TR_PC_W-1:0]   pc;
        logic [TR_INST_W-1:0] inst;
        logic [TR_DATA_W-1:0] alu;
        logic [TR_CCR_W-1:0]  ccr;
    } trace_entry_t;

    typedef enum logic [1:0] {MODE_WRAP, MODE_STOP, MODE_TRIG} trace_mode_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_POST, ST_FROZEN} trace_state_e;

    // Opcode layout: inst[2:0] = type, inst[6:3] = op within the type.
    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_L = 3'd2;
    localparam logic [2:0] TYPE_S = 3'd3;
    localparam logic [2:0] TYPE_B = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;

    localparam logic [6:0] OP_ADD  = {4'h0, TYPE_R};
    localparam logic [6:0] OP_LOAD = {4'h0, TYPE_L};
    localparam logic [6:0] OP_BEQ  = {4'h0, TYPE_B};
    localparam logic [6:0] OP_JUMP = {4'h0, TYPE_J};

    function automatic logic trig_match(input logic [6:0] op, input logic [6:0] ref_op,
                                        input logic [6:0] mask);
        return ((op ^ ref_op) & mask) == 7'd0;
    endfunction
endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// trace_ram: DEPTH x W storage, one synchronous write port and an asynchronous read port.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 68
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular capture of retired-instruction records with class filter,
// opcode trigger and a valid/ready drain port.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int PC_W     = 16,
    parameter int INST_W   = 32,
    parameter int DATA_W   = 16,
    parameter int CCR_W    = 4,
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_arm,
    input  logic                                i_abort,
    input  logic [1:0]                          i_mode,
    input  logic [7:0]                          i_class_en,
    input  logic [6:0]                          i_trig_op,
    input  logic [6:0]                          i_trig_mask,
    input  logic                                i_retire_valid,
    input  logic [PC_W-1:0]                     i_retire_pc,
    input  logic [INST_W-1:0]                   i_retire_inst,
    input  logic [DATA_W-1:0]                   i_retire_alu,
    input  logic [CCR_W-1:0]                    i_retire_ccr,
    output logic                                o_rd_valid,
    input  logic                                i_rd_ready,
    output logic [PC_W+INST_W+DATA_W+CCR_W-1:0] o_rd_data,
    output logic [$clog2(DEPTH):0]              o_count,
    output logic [1:0]                          o_state,
    output logic                                o_overflow,
    output logic                                o_triggered
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + INST_W + DATA_W + CCR_W;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] LAST      = CW'(DEPTH - 1);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_CNT);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("cpu_trace_buffer: DEPTH must be a power of two >= 2");
        end
        if (POST_CNT < 0 || POST_CNT > DEPTH - 1) begin : g_bad_post
            $error("cpu_trace_buffer: POST_CNT must be in 0..DEPTH-1");
        end
    endgenerate

    trace_state_e  r_state;
    trace_mode_e   r_mode;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_post;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_triggered;

    logic          w_cap_state;
    logic          w_capture;
    logic          w_trig_hit;
    logic          w_write;
    logic          w_full;
    logic          w_pop;
    logic [EW-1:0] w_rdata;

    assign w_cap_state = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_capture   = i_retire_valid && i_class_en[i_retire_inst[2:0]] && w_cap_state;
    assign w_trig_hit  = i_retire_valid && (r_state == ST_ARMED) && (r_mode == MODE_TRIG) &&
                         trig_match(i_retire_inst[6:0], i_trig_op, i_trig_mask);
    // A trigger entry is stored even when its class is filtered out.
    assign w_write     = (w_capture || w_trig_hit) && !i_arm && !i_abort;
    assign w_full      = r_count == FULL;
    assign o_rd_valid  = (r_count != '0) && ((r_state == ST_IDLE) || (r_state == ST_FROZEN));
    assign w_pop       = o_rd_valid && i_rd_ready && !i_arm;

    assign o_rd_data   = w_rdata;
    assign o_count     = r_count;
    assign o_state     = r_state;
    assign o_overflow  = r_overflow;
    assign o_triggered = r_triggered;

    trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_write),
        .i_waddr (r_wr_ptr),
        .i_wdata ({i_retire_pc, i_retire_inst, i_retire_alu, i_retire_ccr}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_WRAP;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_post      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_triggered <= 1'b0;
        end else if (i_arm) begin
            r_state     <= ST_ARMED;
            r_mode      <= (i_mode == 2'd3) ? MODE_WRAP : trace_mode_e'(i_mode);
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_post      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_triggered <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_full) begin
                    r_rd_ptr   <= r_rd_ptr + 1'b1;
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end
            case (r_state)
                ST_ARMED: begin
                    if (i_abort) begin
                        r_state <= ST_FROZEN;
                    end else if (w_trig_hit) begin
                        r_triggered <= 1'b1;
                        r_post      <= POST_INIT;
                        r_state     <= (POST_CNT == 0) ? ST_FROZEN : ST_POST;
                    end else if (w_write && r_mode == MODE_STOP && r_count == LAST) begin
                        r_state <= ST_FROZEN;
                    end
                end
                ST_POST: begin
                    if (i_abort) begin
                        r_state <= ST_FROZEN;
                    end else if (w_capture) begin
                        r_post <= r_post - 1'b1;
                        if (r_post == AW'(1)) r_state <= ST_FROZEN;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed checks of capture modes, filter, trigger and drain port
// on a DEPTH=8/POST_CNT=3 buffer plus a POST_CNT=0 build sharing the same stimulus.
module tb_cpu_trace_buffer;
    import cpu_trace_pkg::*;

    localparam int EW = 68;
    localparam logic [31:0] INST_ADD  = {25'h0001234, OP_ADD};
    localparam logic [31:0] INST_BEQ  = {25'h0005678, OP_BEQ};
    localparam logic [31:0] INST_LOAD = {25'h0009ABC, OP_LOAD};
    localparam logic [31:0] INST_JUMP = {25'h000DEF0, OP_JUMP};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm = 1'b0, abort = 1'b0, rd_ready = 1'b0, rv = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [7:0]    class_en = 8'hFF;
    logic [6:0]    trig_op = 7'd0, trig_mask = 7'd0;
    logic [15:0]   rpc = '0, ralu = '0;
    logic [31:0]   rinst = '0;
    logic [3:0]    rccr = '0;
    logic          rd_valid, ovf, trg, z_rd_valid, z_ovf, z_trg;
    logic [EW-1:0] rd_data, z_rd_data;
    logic [3:0]    cnt, z_cnt;
    logic [1:0]    st, z_st;
    trace_entry_t  e;
    int            n_checks = 0, n_fail = 0;

    assign e = rd_data;
    always #5 clk = ~clk;

    cpu_trace_buffer #(.DEPTH(8), .POST_CNT(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_arm(arm), .i_abort(abort), .i_mode(mode),
        .i_class_en(class_en), .i_trig_op(trig_op), .i_trig_mask(trig_mask),
        .i_retire_valid(rv), .i_retire_pc(rpc), .i_retire_inst(rinst),
        .i_retire_alu(ralu), .i_retire_ccr(rccr), .o_rd_valid(rd_valid),
        .i_rd_ready(rd_ready), .o_rd_data(rd_data), .o_count(cnt), .o_state(st),
        .o_overflow(ovf), .o_triggered(trg)
    );

    cpu_trace_buffer #(.DEPTH(8), .POST_CNT(0)) dut_z (
        .i_clk(clk), .i_rst_n(rst_n), .i_arm(arm), .i_abort(abort), .i_mode(mode),
        .i_class_en(class_en), .i_trig_op(trig_op), .i_trig_mask(trig_mask),
        .i_retire_valid(rv), .i_retire_pc(rpc), .i_retire_inst(rinst),
        .i_retire_alu(ralu), .i_retire_ccr(rccr), .o_rd_valid(z_rd_valid),
        .i_rd_ready(rd_ready), .o_rd_data(z_rd_data), .o_count(z_cnt), .o_state(z_st),
        .o_overflow(z_ovf), .o_triggered(z_trg)
    );

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [1:0] m);
        mode = m;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic retire(input int pc, input logic [31:0] inst);
        rv = 1'b1;
        rpc = 16'(pc);
        rinst = inst;
        ralu = {rpc[7:0], 8'h5A};
        rccr = rpc[3:0];
        tick();
        rv = 1'b0;
    endtask

    // Pops n entries expecting consecutive pcs from first; entry jump_idx holds a JUMP.
    task automatic drain(input int first, input int n, input int jump_idx);
        logic [15:0] p;
        for (int i = 0; i < n; i++) begin
            p = 16'(first + i);
            check("rd_valid", EW'(rd_valid), EW'(1'b1));
            check("rd_pc", EW'(e.pc), EW'(p));
            check("rd_inst", EW'(e.inst), EW'((i == jump_idx) ? INST_JUMP : INST_ADD));
            check("rd_alu", EW'(e.alu), EW'({p[7:0], 8'h5A}));
            check("rd_ccr", EW'(e.ccr), EW'(p[3:0]));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        check("drained_count", EW'(cnt), EW'(0));
        check("drained_valid", EW'(rd_valid), EW'(1'b0));
    endtask

    initial begin
        logic [EW-1:0] held;
        int bpc [3] = '{1, 3, 5};
        repeat (2) tick();
        check("rst_state", EW'(st), EW'(ST_IDLE));
        check("rst_count", EW'(cnt), EW'(0));
        check("rst_valid", EW'(rd_valid), EW'(1'b0));
        check("rst_ovf", EW'(ovf), EW'(1'b0));
        check("rst_trg", EW'(trg), EW'(1'b0));
        rst_n = 1'b1;

        // Asynchronous reset mid-capture
        do_arm(2'd0);
        for (int i = 0; i < 5; i++) retire(i, INST_ADD);
        check("t1_count_pre", EW'(cnt), EW'(5));
        check("t1_state_pre", EW'(st), EW'(ST_ARMED));
        #2 rst_n = 1'b0;
        #1;
        check("t1_count", EW'(cnt), EW'(0));
        check("t1_state", EW'(st), EW'(ST_IDLE));
        check("t1_valid", EW'(rd_valid), EW'(1'b0));
        #1 rst_n = 1'b1;

        // STOP mode freezes on the eighth write
        do_arm(2'd1);
        for (int i = 0; i < 10; i++) begin
            retire(i, INST_ADD);
            if (i == 6) check("t2_state_7", EW'(st), EW'(ST_ARMED));
            if (i == 7) check("t2_state_8", EW'(st), EW'(ST_FROZEN));
        end
        check("t2_count", EW'(cnt), EW'(8));
        check("t2_ovf", EW'(ovf), EW'(1'b0));
        drain(0, 8, -1);
        check("t2_frozen_after_pop", EW'(st), EW'(ST_FROZEN));

        // WRAP mode overwrites the oldest entries
        do_arm(2'd0);
        check("t3_ovf_cleared", EW'(ovf), EW'(1'b0));
        for (int i = 0; i < 10; i++) retire(i, INST_ADD);
        check("t3_no_read_armed", EW'(rd_valid), EW'(1'b0));
        do_abort();
        check("t3_state", EW'(st), EW'(ST_FROZEN));
        check("t3_count", EW'(cnt), EW'(8));
        check("t3_ovf", EW'(ovf), EW'(1'b1));
        drain(2, 8, -1);

        // TRIG mode: JUMP at pc 6, three post-trigger entries
        trig_op = OP_JUMP;
        trig_mask = 7'h7F;
        do_arm(2'd2);
        for (int i = 0; i < 12; i++) begin
            retire(i, (i == 6) ? INST_JUMP : INST_ADD);
            if (i == 5) check("t4_z_armed", EW'(z_st), EW'(ST_ARMED));
            if (i == 6) begin
                check("t4_post", EW'(st), EW'(ST_POST));
                check("t4_trg", EW'(trg), EW'(1'b1));
                check("t4_z_frozen", EW'(z_st), EW'(ST_FROZEN));
                check("t4_z_count", EW'(z_cnt), EW'(7));
            end
            if (i == 8) check("t4_still_post", EW'(st), EW'(ST_POST));
            if (i == 9) check("t4_frozen", EW'(st), EW'(ST_FROZEN));
        end
        check("t4_count", EW'(cnt), EW'(8));
        check("t4_ovf", EW'(ovf), EW'(1'b1));
        drain(2, 8, 4);

        // Class filter keeps only branch entries
        class_en = 8'h01 << TYPE_B;
        do_arm(2'd0);
        check("t5_trg_cleared", EW'(trg), EW'(1'b0));
        retire(0, INST_ADD);
        retire(1, INST_BEQ);
        retire(2, INST_LOAD);
        retire(3, INST_BEQ);
        retire(4, INST_ADD);
        retire(5, INST_BEQ);
        retire(6, INST_LOAD);
        check("t5_count", EW'(cnt), EW'(3));
        do_abort();
        for (int i = 0; i < 3; i++) begin
            check("t5_pc", EW'(e.pc), EW'(16'(bpc[i])));
            check("t5_inst", EW'(e.inst), EW'(INST_BEQ));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        check("t5_empty", EW'(rd_valid), EW'(1'b0));
        class_en = 8'hFF;

        // arm beats abort in the same cycle
        arm = 1'b1;
        abort = 1'b1;
        mode = 2'd0;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        check("t6_arm_abort_state", EW'(st), EW'(ST_ARMED));
        check("t6_arm_abort_count", EW'(cnt), EW'(0));

        // rd_data holds while the consumer stalls
        for (int i = 20; i < 23; i++) retire(i, INST_ADD);
        do_abort();
        held = rd_data;
        check("t6_head_pc", EW'(e.pc), EW'(20));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_stall_data", rd_data, held);
            check("t6_stall_count", EW'(cnt), EW'(3));
        end
        drain(20, 3, -1);

        // Reserved mode 3 behaves as WRAP
        do_arm(2'd3);
        for (int i = 30; i < 39; i++) retire(i, INST_ADD);
        check("t7_state", EW'(st), EW'(ST_ARMED));
        do_abort();
        check("t7_count", EW'(cnt), EW'(8));
        check("t7_ovf", EW'(ovf), EW'(1'b1));
        check("t7_head_pc", EW'(e.pc), EW'(31));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
